// File: rtl/fft_seq_ctrl_pkg.sv
// Shared definitions for the FFT stage sequencer.
//   DEF_FFT_SIZE : default maximum transform size
//   seq_state_t  : sequencer state encoding
//   levels_legal : range check for a runtime stage count
package fft_seq_ctrl_pkg;

  localparam int unsigned DEF_FFT_SIZE = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STAGE,
    ST_DRAIN,
    ST_UNLOAD
  } seq_state_t;

  function automatic logic levels_legal(input int unsigned lv,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (lv >= lo) && (lv <= hi);
  endfunction

endpackage

// File: rtl/fft_seq_ctrl.sv
// FFT frame sequencer: LOAD -> STAGE/STAGE_DRAIN per level -> UNLOAD.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   fft_go, abort              : frame start request / frame abort
//   cfg_levels, cfg_scale_mask,
//   cfg_continuous             : per-frame configuration, latched at start
//   *_busy, fft_data_valid     : sub-block status
//   *_go                       : one-cycle start pulses to sub-blocks
//   fft_level                  : current stage index
//   wmem_id, rmem_id           : ping-pong memory selects
//   axis_rx, axis_tx, scale    : stream mux selects, butterfly divide-by-2
//   fft_busy                   : high whenever not idle
//   frame_done, cfg_err        : one-cycle status pulses
//   frame_count                : completed frame counter (wraps)
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter  int unsigned FFT_SIZE   = DEF_FFT_SIZE,
  parameter  int unsigned MIN_LEVELS = 3,
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned LEVELS     = $clog2(FFT_SIZE),
  localparam int unsigned CFG_W      = $clog2(LEVELS + 1),
  localparam int unsigned LVL_W      = $clog2(LEVELS)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fft_go,
  input  logic                 abort,
  input  logic [CFG_W-1:0]     cfg_levels,
  input  logic [LEVELS-1:0]    cfg_scale_mask,
  input  logic                 cfg_continuous,
  input  logic                 axis_bram_slave_busy,
  input  logic                 addr_gen_busy,
  input  logic                 axis_bram_master_busy,
  input  logic                 fft_data_valid,
  output logic                 axis_bram_slave_go,
  output logic                 addr_gen_go,
  output logic                 axis_bram_master_go,
  output logic [LVL_W-1:0]     fft_level,
  output logic                 wmem_id,
  output logic                 rmem_id,
  output logic                 axis_rx,
  output logic                 axis_tx,
  output logic                 scale,
  output logic                 fft_busy,
  output logic                 frame_done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] frame_count
);

  seq_state_t            state, state_n;
  logic [LVL_W-1:0]      level_n;
  logic [1:0]            go_age, go_age_n;
  logic [CFG_W-1:0]      lat_levels, lat_levels_n;
  logic [LEVELS-1:0]     lat_mask, lat_mask_n;
  logic                  lat_cont, lat_cont_n;
  logic [CNT_WIDTH-1:0]  count_n;
  logic                  slave_go_n, addr_go_n, master_go_n;
  logic                  done_n, err_n;
  logic                  cfg_ok, busy_ok, more_stages;

  assign cfg_ok      = levels_legal(32'(cfg_levels), MIN_LEVELS, LEVELS);
  // Sub-block busy flags lag their go pulse; only trust them from the
  // second cycle after go onward.
  assign busy_ok     = (go_age == 2'd2);
  assign more_stages = CFG_W'(fft_level) < (lat_levels - CFG_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      fft_level           <= '0;
      go_age              <= '0;
      lat_levels          <= '0;
      lat_mask            <= '0;
      lat_cont            <= 1'b0;
      frame_count         <= '0;
      axis_bram_slave_go  <= 1'b0;
      addr_gen_go         <= 1'b0;
      axis_bram_master_go <= 1'b0;
      frame_done          <= 1'b0;
      cfg_err             <= 1'b0;
    end else begin
      state               <= state_n;
      fft_level           <= level_n;
      go_age              <= go_age_n;
      lat_levels          <= lat_levels_n;
      lat_mask            <= lat_mask_n;
      lat_cont            <= lat_cont_n;
      frame_count         <= count_n;
      axis_bram_slave_go  <= slave_go_n;
      addr_gen_go         <= addr_go_n;
      axis_bram_master_go <= master_go_n;
      frame_done          <= done_n;
      cfg_err             <= err_n;
    end
  end

  // Next-state logic. Go pulses and status pulses are registered so they
  // land in the first cycle of the state they belong to.
  always_comb begin
    state_n      = state;
    level_n      = fft_level;
    go_age_n     = busy_ok ? 2'd2 : go_age + 2'd1;
    lat_levels_n = lat_levels;
    lat_mask_n   = lat_mask;
    lat_cont_n   = lat_cont;
    count_n      = frame_count;
    slave_go_n   = 1'b0;
    addr_go_n    = 1'b0;
    master_go_n  = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fft_go) begin
          if (cfg_ok) begin
            lat_levels_n = cfg_levels;
            lat_mask_n   = cfg_scale_mask;
            lat_cont_n   = cfg_continuous;
            state_n      = ST_LOAD;
            go_age_n     = '0;
            slave_go_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (busy_ok && !axis_bram_slave_busy) begin
          state_n   = ST_STAGE;
          level_n   = '0;
          go_age_n  = '0;
          addr_go_n = 1'b1;
        end
      end
      ST_STAGE: begin
        if (busy_ok && !addr_gen_busy) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!fft_data_valid) begin
          go_age_n = '0;
          if (more_stages) begin
            state_n   = ST_STAGE;
            level_n   = fft_level + LVL_W'(1);
            addr_go_n = 1'b1;
          end else begin
            state_n     = ST_UNLOAD;
            master_go_n = 1'b1;
          end
        end
      end
      ST_UNLOAD: begin
        if (busy_ok && !axis_bram_master_busy) begin
          done_n  = 1'b1;
          count_n = frame_count + CNT_WIDTH'(1);
          state_n = ST_IDLE;
          if (lat_cont) begin
            if (cfg_ok) begin
              lat_levels_n = cfg_levels;
              lat_mask_n   = cfg_scale_mask;
              lat_cont_n   = cfg_continuous;
              state_n      = ST_LOAD;
              go_age_n     = '0;
              slave_go_n   = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort overrides any completion evaluated above in the same cycle.
    if (abort && (state != ST_IDLE)) begin
      state_n      = ST_IDLE;
      level_n      = fft_level;
      lat_levels_n = lat_levels;
      lat_mask_n   = lat_mask;
      lat_cont_n   = lat_cont;
      count_n      = frame_count;
      slave_go_n   = 1'b0;
      addr_go_n    = 1'b0;
      master_go_n  = 1'b0;
      done_n       = 1'b0;
      err_n        = 1'b0;
    end
  end

  always_comb begin
    fft_busy = (state != ST_IDLE);
    axis_rx  = (state == ST_LOAD);
    axis_tx  = (state == ST_UNLOAD);
    rmem_id  = 1'b0;
    wmem_id  = 1'b0;
    scale    = 1'b0;
    unique case (state)
      ST_STAGE, ST_DRAIN: begin
        rmem_id = fft_level[0];
        wmem_id = ~fft_level[0];
        scale   = lat_mask[fft_level];
      end
      ST_UNLOAD: rmem_id = lat_levels[0];
      default: ;
    endcase
  end

endmodule
